// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU (port A)
// and a debug/loader requester (port B). The CPU normally wins; a port B
// request that has waited MAX_WAIT cycles is given priority for one transfer.
// Port B writes into the I/O window (F0:FF) can be blocked by B_IO_WR.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int B_IO_WR  = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [7:0] addr_a,
  input  logic [7:0] wdata_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [7:0] addr_b,
  input  logic [7:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       err_b,
  output logic       mem_wmem,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout
);

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);
  localparam logic [7:0] IO_BASE    = 8'hF0;
  localparam logic       B_IO_WR_EN = (B_IO_WR != 0);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  pri_t       pri_q;
  logic [3:0] wait_b_q;
  logic [3:0] wait_b_nxt;
  logic       gnt_a_int;
  logic       gnt_b_int;
  logic       rej_b;

  logic       done_a_p1;
  logic       done_b_p1;
  logic       err_b_p1;
  logic [7:0] rdata_a_p1;
  logic [7:0] rdata_b_p1;

  // Pick this cycle's winner from the current priority state
  always_comb begin
    gnt_a_int = 1'b0;
    gnt_b_int = 1'b0;
    if (pri_q == PRI_B) begin
      gnt_b_int = req_b;
      gnt_a_int = req_a && !req_b;
    end else begin
      gnt_a_int = req_a;
      gnt_b_int = req_b && !req_a;
    end
  end

  // A port B write into the I/O window is consumed but never reaches memory
  assign rej_b = we_b && (addr_b >= IO_BASE) && !B_IO_WR_EN;

  // While reset is held nothing is granted, so no access can slip through
  assign gnt_a = gnt_a_int && reset_n;
  assign gnt_b = gnt_b_int && reset_n;

  // Steer the granted port onto the memory bus; idle bus is all zeros
  always_comb begin
    mem_wmem = 1'b0;
    mem_addr = 8'h00;
    mem_din  = 8'h00;
    if (gnt_a) begin
      mem_wmem = we_a;
      mem_addr = addr_a;
      mem_din  = wdata_a;
    end else if (gnt_b) begin
      mem_wmem = we_b && !rej_b;
      mem_addr = addr_b;
      mem_din  = wdata_b;
    end
  end

  // Starvation counter for port B: counts denied cycles, saturates at MAX_WAIT
  always_comb begin
    wait_b_nxt = 4'd0;
    if (req_b && !gnt_b_int) begin
      if (wait_b_q >= MAX_WAIT_L) begin
        wait_b_nxt = MAX_WAIT_L;
      end else begin
        wait_b_nxt = wait_b_q + 4'd1;
      end
    end
  end

  // Priority FSM: B takes priority once its wait hits the limit, for one transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pri_q    <= PRI_A;
      wait_b_q <= 4'd0;
    end else begin
      wait_b_q <= wait_b_nxt;
      case (pri_q)
        PRI_A: if (wait_b_nxt == MAX_WAIT_L) pri_q <= PRI_B;
        PRI_B: if (!req_b || gnt_b_int) pri_q <= PRI_A;
        default: pri_q <= PRI_A;
      endcase
    end
  end

  // Response stage: done/err pulse the cycle after a transfer, reads capture mem_dout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_a_p1  <= 1'b0;
      done_b_p1  <= 1'b0;
      err_b_p1   <= 1'b0;
      rdata_a_p1 <= 8'h00;
      rdata_b_p1 <= 8'h00;
    end else begin
      done_a_p1 <= req_a && gnt_a_int;
      done_b_p1 <= req_b && gnt_b_int;
      err_b_p1  <= req_b && gnt_b_int && rej_b;
      if (req_a && gnt_a_int && !we_a) rdata_a_p1 <= mem_dout;
      if (req_b && gnt_b_int && !we_b) rdata_b_p1 <= mem_dout;
    end
  end

  assign done_a  = done_a_p1;
  assign done_b  = done_b_p1;
  assign err_b   = err_b_p1;
  assign rdata_a = rdata_a_p1;
  assign rdata_b = rdata_b_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed stimulus, a transaction-level model
// of the arbitration rules and memory contents, and literal spot checks.
module tb_dmem_arbiter;

  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_a, we_a, req_b, we_b;
  logic [7:0] addr_a, wdata_a, addr_b, wdata_b;

  logic       gnt_a, gnt_b, done_a, done_b, err_b, mem_wmem;
  logic [7:0] rdata_a, rdata_b, mem_addr, mem_din, mem_dout;

  logic       gnt_a_io, gnt_b_io, done_a_io, done_b_io, err_b_io, mem_wmem_io;
  logic [7:0] rdata_a_io, rdata_b_io, mem_addr_io, mem_din_io, mem_dout_io;

  logic [7:0] env_mem [256];
  logic [7:0] io_mem  [256];
  logic [7:0] ref_mem [256];

  int total = 0;
  int bad   = 0;

  // model state
  int         b_waited = 0;
  logic       m_done_a = 1'b0, m_done_b = 1'b0, m_err_b = 1'b0;
  logic [7:0] m_rdata_a = 8'h00, m_rdata_b = 8'h00;
  logic       mg_a, mg_b;
  logic       eg_a, eg_b, e_wmem;
  logic [7:0] e_addr, e_din;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MW), .B_IO_WR(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .err_b(err_b),
    .mem_wmem(mem_wmem), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  dmem_arbiter #(.MAX_WAIT(MW), .B_IO_WR(1)) dut_io (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a_io), .gnt_b(gnt_b_io), .done_a(done_a_io), .done_b(done_b_io),
    .rdata_a(rdata_a_io), .rdata_b(rdata_b_io), .err_b(err_b_io),
    .mem_wmem(mem_wmem_io), .mem_addr(mem_addr_io), .mem_din(mem_din_io), .mem_dout(mem_dout_io)
  );

  // memories seen by the two instances
  assign mem_dout    = env_mem[mem_addr];
  assign mem_dout_io = io_mem[mem_addr_io];

  always @(posedge clk) if (mem_wmem) env_mem[mem_addr] <= mem_din;
  always @(posedge clk) if (mem_wmem_io) io_mem[mem_addr_io] <= mem_din_io;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // B wins when it has been kept waiting MW cycles, or when A is not asking
  function automatic logic exp_gnt_b_f();
    return reset_n && req_b && ((b_waited >= MW) || !req_a);
  endfunction

  function automatic logic exp_gnt_a_f();
    return reset_n && req_a && !exp_gnt_b_f();
  endfunction

  // model: apply each cycle's transfer at the clock edge
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        b_waited  = 0;
        m_done_a  = 1'b0;
        m_done_b  = 1'b0;
        m_err_b   = 1'b0;
        m_rdata_a = 8'h00;
        m_rdata_b = 8'h00;
      end else begin
        mg_a = exp_gnt_a_f();
        mg_b = exp_gnt_b_f();
        m_done_a = mg_a;
        m_done_b = mg_b;
        m_err_b  = 1'b0;
        if (mg_a) begin
          if (we_a) ref_mem[addr_a] = wdata_a;
          else m_rdata_a = ref_mem[addr_a];
        end
        if (mg_b) begin
          if (we_b) begin
            if (addr_b >= 8'hF0) m_err_b = 1'b1;
            else ref_mem[addr_b] = wdata_b;
          end else begin
            m_rdata_b = ref_mem[addr_b];
          end
        end
        if (req_b && !mg_b) b_waited++;
        else b_waited = 0;
      end
    end
  end

  // compare every cycle outside reset
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        eg_b = exp_gnt_b_f();
        eg_a = exp_gnt_a_f();
        e_wmem = 1'b0;
        e_addr = 8'h00;
        e_din  = 8'h00;
        if (eg_a) begin
          e_wmem = we_a; e_addr = addr_a; e_din = wdata_a;
        end else if (eg_b) begin
          e_wmem = we_b && (addr_b < 8'hF0); e_addr = addr_b; e_din = wdata_b;
        end
        chk1("m_gnt_a", gnt_a, eg_a);
        chk1("m_gnt_b", gnt_b, eg_b);
        chk1("m_mem_wmem", mem_wmem, e_wmem);
        chk8("m_mem_addr", mem_addr, e_addr);
        chk8("m_mem_din", mem_din, e_din);
        chk1("m_done_a", done_a, m_done_a);
        chk1("m_done_b", done_b, m_done_b);
        chk1("m_err_b", err_b, m_err_b);
        chk8("m_rdata_a", rdata_a, m_rdata_a);
        chk8("m_rdata_b", rdata_b, m_rdata_b);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
    req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;
  endtask

  task automatic set_a(input logic we, input logic [7:0] a, input logic [7:0] d);
    req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
  endtask

  task automatic set_b(input logic we, input logic [7:0] a, input logic [7:0] d);
    req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = 8'(i) ^ 8'hA5;
    env_mem[8'h10] = 8'h5A;
    for (int i = 0; i < 256; i++) begin
      io_mem[i]  = env_mem[i];
      ref_mem[i] = env_mem[i];
    end
    idle();
    reset_n = 1'b0;

    // reset values
    smp();
    chk1("rst_gnt_a", gnt_a, 1'b0);
    chk1("rst_gnt_b", gnt_b, 1'b0);
    chk1("rst_done_a", done_a, 1'b0);
    chk1("rst_done_b", done_b, 1'b0);
    chk1("rst_err_b", err_b, 1'b0);
    chk8("rst_rdata_a", rdata_a, 8'h00);
    chk8("rst_rdata_b", rdata_b, 8'h00);
    chk1("rst_mem_wmem", mem_wmem, 1'b0);
    chk8("rst_mem_addr", mem_addr, 8'h00);
    chk8("rst_mem_din", mem_din, 8'h00);
    nxt();
    reset_n = 1'b1;
    smp();

    // single read on A
    nxt(); set_a(1'b0, 8'h10, 8'h00);
    smp();
    chk1("rd_gnt_a", gnt_a, 1'b1);
    chk1("rd_wmem0", mem_wmem, 1'b0);
    chk8("rd_addr", mem_addr, 8'h10);
    nxt(); idle();
    smp();
    chk1("rd_done_a", done_a, 1'b1);
    chk8("rd_rdata_a", rdata_a, 8'h5A);
    chk1("rd_wmem1", mem_wmem, 1'b0);
    nxt();
    smp();
    chk1("rd_done_a_once", done_a, 1'b0);

    // B write 3C to 20, then read it back
    nxt(); set_b(1'b1, 8'h20, 8'h3C);
    smp();
    chk1("wb_wmem", mem_wmem, 1'b1);
    chk8("wb_din", mem_din, 8'h3C);
    nxt(); set_b(1'b0, 8'h20, 8'h00);
    smp();
    chk1("wb_done1", done_b, 1'b1);
    chk1("wb_wmem_rd", mem_wmem, 1'b0);
    nxt(); idle();
    smp();
    chk1("wb_done2", done_b, 1'b1);
    chk8("wb_rdata_b", rdata_b, 8'h3C);
    nxt();
    smp();
    chk1("wb_done_end", done_b, 1'b0);

    // starvation: A held high, B granted in cycle 4
    nxt(); set_a(1'b0, 8'h30, 8'h00); set_b(1'b0, 8'h40, 8'h00);
    smp();
    chk1("st_gnt_a_c0", gnt_a, 1'b1);
    chk1("st_gnt_b_c0", gnt_b, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      nxt();
      smp();
      chk1("st_gnt_b_wait", gnt_b, 1'b0);
    end
    nxt();
    smp();
    chk1("st_gnt_b_c4", gnt_b, 1'b1);
    chk1("st_gnt_a_c4", gnt_a, 1'b0);
    nxt(); req_b = 1'b0;
    smp();
    chk1("st_gnt_a_c5", gnt_a, 1'b1);
    chk1("st_done_b_c5", done_b, 1'b1);
    chk8("st_rdata_b", rdata_b, 8'hE5);
    nxt(); idle();
    smp();

    // simultaneous first requests out of reset
    nxt(); reset_n = 1'b0;
    smp();
    nxt(); reset_n = 1'b1;
    set_a(1'b0, 8'h11, 8'h00); set_b(1'b0, 8'h12, 8'h00);
    smp();
    chk1("sim_gnt_a", gnt_a, 1'b1);
    chk1("sim_gnt_b", gnt_b, 1'b0);
    nxt(); req_a = 1'b0;
    smp();
    chk1("sim_gnt_b_after", gnt_b, 1'b1);
    nxt(); idle();
    smp();

    // I/O window protection on B
    nxt(); set_b(1'b1, 8'hF2, 8'h77);
    smp();
    chk1("io_gnt_b", gnt_b, 1'b1);
    chk1("io_wmem_blocked", mem_wmem, 1'b0);
    chk1("io_wmem_allowed", mem_wmem_io, 1'b1);
    nxt(); set_b(1'b0, 8'hF2, 8'h00);
    smp();
    chk1("io_done_b", done_b, 1'b1);
    chk1("io_err_b", err_b, 1'b1);
    chk1("io_done_b_io", done_b_io, 1'b1);
    chk1("io_err_b_io", err_b_io, 1'b0);
    chk8("io_port_kept", env_mem[8'hF2], 8'h57);
    chk8("io_port_written", io_mem[8'hF2], 8'h77);
    nxt(); idle();
    smp();
    chk8("io_rd_blocked", rdata_b, 8'h57);
    chk8("io_rd_allowed", rdata_b_io, 8'h77);
    chk1("io_err_clear", err_b, 1'b0);

    // reset in the middle of A reads while B is waiting
    nxt(); set_a(1'b0, 8'h10, 8'h00); set_b(1'b0, 8'h50, 8'h00);
    smp();
    chk1("mr_gnt_a", gnt_a, 1'b1);
    nxt();
    smp();
    nxt();
    smp();
    chk1("mr_gnt_b_c2", gnt_b, 1'b0);
    nxt();
    chk1("mr_done_a_pre", done_a, 1'b1);
    chk8("mr_rdata_a_pre", rdata_a, 8'h5A);
    #1;
    reset_n = 1'b0;
    #1;
    chk1("mr_done_a_rst", done_a, 1'b0);
    chk8("mr_rdata_a_rst", rdata_a, 8'h00);
    chk1("mr_wmem_rst", mem_wmem, 1'b0);
    smp();
    nxt(); reset_n = 1'b1; idle();
    smp();
    chk1("mr_no_done_a", done_a, 1'b0);
    nxt(); set_a(1'b0, 8'h10, 8'h00); set_b(1'b0, 8'h50, 8'h00);
    smp();
    chk1("mr_gnt_b_c0", gnt_b, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      nxt();
      smp();
      chk1("mr_gnt_b_wait", gnt_b, 1'b0);
    end
    nxt();
    smp();
    chk1("mr_gnt_b_c4", gnt_b, 1'b1);
    nxt(); idle();
    smp();
    nxt();
    smp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single data-memory port (RAM 00:EF, output ports F0:F7, input ports F8:FF) between the CPU (port A) and a debug/loader requester (port B). It drives the memory's write-enable, address and write data, captures its asynchronous read data into per-port response registers, and enforces fixed CPU priority with a bounded starvation override for port B. Port B writes into the I/O window can be rejected by parameter.

## Interface
- MAX_WAIT, 4: pending-B cycles without a grant before B gets priority (1..15)
- B_IO_WR, 0: 1 allows B writes to F0:FF; 0 rejects them
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_a / req_b  in  1  request valid, per port
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  8  address
- wdata_a / wdata_b  in  8  write data
- gnt_a / gnt_b  out  1  combinational; transfer occurs in a cycle where req_x && gnt_x
- done_a / done_b  out  1  registered pulse, cycle after a transfer
- rdata_a / rdata_b  out  8  read data, valid while done_x after a read
- err_b  out  1  registered pulse with done_b for a rejected write
- mem_wmem  out  1  memory write enable
- mem_addr  out  8  memory address
- mem_din  out  8  memory write data
- mem_dout  in  8  memory read data (asynchronous)

## Operation
- One clock; reset is asynchronous and active-low.
- At most one transfer per cycle. Requester holds req/we/addr/wdata stable until granted; may present a new request in the cycle after a transfer (back-to-back allowed).
- Policy FSM, states PRI_A (reset) and PRI_B:
  - PRI_A: gnt_a = req_a; gnt_b = req_b && !req_a.
  - PRI_B: gnt_b = req_b; gnt_a = req_a && !req_b.
  - PRI_A -> PRI_B when wait_b will reach MAX_WAIT at this edge. PRI_B -> PRI_A on a B transfer, or if req_b drops.
- wait_b (4-bit): +1 each cycle req_b && !gnt_b; cleared on a B transfer or when req_b = 0; saturates at MAX_WAIT.
- Memory drive: granted port's addr/wdata onto mem_addr/mem_din; mem_wmem = granted we, except a B write with addr >= F0 when B_IO_WR = 0 (mem_wmem = 0, transfer still consumed). No grant: mem_wmem = 0, mem_addr = 00, mem_din = 00.
- Response: at the transfer edge done_x <= 1; on a read rdata_x <= mem_dout; on a write rdata_x holds. err_b <= 1 for a rejected B write. Non-transferring port: done/err <= 0.

## Timing
- Reset values: gnt_a = gnt_b = 0 (no req), done_a = done_b = 0, err_b = 0, rdata_a = rdata_b = 00, mem_wmem = 0, mem_addr = 00, mem_din = 00, FSM PRI_A, wait_b = 0.
- Read latency 1: request granted in cycle N, rdata_x/done_x valid in N+1 for exactly one cycle.
- Write commits at the end of the grant cycle N; a read of the same address granted in N+1 returns the new value.
- A continuously requesting B is granted no later than MAX_WAIT+1 cycles after first asserting req_b, even with req_a held high.
- After PRI_B is entered and B is served, A regains priority the next cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); any access in that cycle is lost; no done pulse after release.

## Test plan
- Single read: mem holds 5A at 10; req_a, we_a = 0, addr_a = 10 -> gnt_a same cycle, done_a = 1 and rdata_a = 5A next cycle, mem_wmem = 0 throughout.
- Write then read-back on B: B writes 3C to 20, next cycle reads 20 -> mem_wmem = 1 only in cycle 1, done_b pulses in cycles 2 and 3, rdata_b = 3C in cycle 3.
- Starvation: req_a held high every cycle, req_b asserted at cycle 0, MAX_WAIT = 4 -> gnt_b = 0 for cycles 0-3, gnt_b = 1 and gnt_a = 0 in cycle 4, gnt_a = 1 again in cycle 5.
- Simultaneous first requests from reset -> A granted; B granted the first cycle req_a drops.
- Protection: B_IO_WR = 0, B writes 77 to F2 -> mem_wmem = 0, done_b = 1 and err_b = 1 next cycle, port F2 unchanged; repeat with B_IO_WR = 1 -> write occurs, err_b = 0.
- Reset mid-transfer: reset_n low during a granted A read -> done_a, rdata_a, FSM, wait_b cleared immediately; no done_a after reset_n rises.
